// File: rtl/spi_slave_if.sv
// SPI slave bus bundle: serial pins plus the
// parallel tx/rx handshake and status pulses.
interface spi_slave_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  sclk;
  logic                  ss_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  busy;
  logic                  irq;
  logic                  tx_underrun;
  logic                  frame_err;

  modport slave (
    input  sclk, ss_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data,
    output rx_valid, busy, irq, tx_underrun,
    output frame_err
  );

  modport master (
    output sclk, ss_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data,
    input  rx_valid, busy, irq, tx_underrun,
    input  frame_err
  );
endinterface

// File: rtl/spi_slave.sv
// SPI slave, all four modes, oversampled on clk.
// Pins are synchronised; edges drive the FSM.
module spi_slave #(
  parameter int MODE       = 0,
  parameter int DATA_WIDTH = 16
) (
  input logic       clk,
  input logic       rst,
  spi_slave_if.slave bus
);
  localparam logic CPOL = MODE[1];
  localparam logic CPHA = MODE[0];
  localparam int   CW   = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    WAIT_DESEL,
    IDLE,
    ACTIVE
  } state_t;

  state_t state_q, state_d;

  // [0]/[1] synchroniser, [2] history
  logic [2:0] sclk_sy, ss_sy, mosi_sy;
  logic [1:0] settle;

  logic [DATA_WIDTH-1:0] hold_q, tx_sr, rx_sr;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  hold_full, skip, pend_ur;
  logic [CW-1:0]         bit_cnt;
  logic rx_valid_q, ur_q, fe_q;

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic lead, trail, sample_edge, shift_edge;
  logic load_entry, load_wrap, load;
  logic sample_en, shift_en, abort, tx_ready;

  assign sclk_rise = sclk_sy[1] & ~sclk_sy[2];
  assign sclk_fall = ~sclk_sy[1] & sclk_sy[2];
  assign ss_rise   = ss_sy[1] & ~ss_sy[2];
  assign ss_fall   = ~ss_sy[1] & ss_sy[2];

  assign lead  = CPOL ? sclk_fall : sclk_rise;
  assign trail = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail : lead;
  assign shift_edge  = CPHA ? lead : trail;

  assign load     = load_entry | load_wrap;
  assign tx_ready = ~hold_full & ~load;

  // Pin synchronisers and post-reset settle count
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sy <= {3{CPOL}};
      ss_sy   <= 3'b111;
      mosi_sy <= 3'b000;
      settle  <= 2'd0;
    end else begin
      sclk_sy <= {sclk_sy[1:0], bus.sclk};
      ss_sy   <= {ss_sy[1:0], bus.ss_n};
      mosi_sy <= {mosi_sy[1:0], bus.mosi};
      if (settle != 2'd3)
        settle <= settle + 2'd1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= WAIT_DESEL;
    else     state_q <= state_d;
  end

  // Next state and per-cycle strobes
  always_comb begin
    state_d    = state_q;
    load_entry = 1'b0;
    load_wrap  = 1'b0;
    sample_en  = 1'b0;
    shift_en   = 1'b0;
    abort      = 1'b0;
    unique case (state_q)
      WAIT_DESEL: begin
        if (settle == 2'd3 && ss_sy[1])
          state_d = IDLE;
      end
      IDLE: begin
        if (ss_fall) begin
          state_d    = ACTIVE;
          load_entry = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d = IDLE;
          abort   = (bit_cnt != '0);
        end else begin
          sample_en = sample_edge;
          shift_en  = shift_edge;
          load_wrap = sample_edge &&
                      bit_cnt == LAST;
        end
      end
      default: state_d = WAIT_DESEL;
    endcase
  end

  // Holding register, shifters, counter, pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= '0;
      hold_full  <= 1'b0;
      tx_sr      <= '0;
      skip       <= 1'b0;
      pend_ur    <= 1'b0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ur_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      ur_q       <= 1'b0;
      fe_q       <= abort;

      if (load)
        hold_full <= 1'b0;
      else if (bus.tx_valid && tx_ready) begin
        hold_q    <= bus.tx_data;
        hold_full <= 1'b1;
      end

      // The edge right after a reload belongs to the
      // previous bit (CPHA=0) or presents the MSB (CPHA=1).
      if (load) begin
        tx_sr <= hold_full ? hold_q : '0;
        skip  <= load_wrap | CPHA;
      end else if (shift_en) begin
        if (skip) skip <= 1'b0;
        else tx_sr <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
      end

      // A wrap-time underrun only counts once the
      // master actually clocks the next frame.
      if (load) begin
        ur_q    <= load_entry & ~hold_full;
        pend_ur <= load_wrap & ~hold_full;
      end else if (state_d != ACTIVE)
        pend_ur <= 1'b0;
      else if (sample_en && pend_ur) begin
        pend_ur <= 1'b0;
        ur_q    <= 1'b1;
      end

      if (state_d != ACTIVE) begin
        bit_cnt <= '0;
        rx_sr   <= '0;
      end else if (sample_en) begin
        rx_sr <= {rx_sr[DATA_WIDTH-2:0], mosi_sy[2]};
        if (load_wrap) begin
          bit_cnt    <= '0;
          rx_data_q  <= {rx_sr[DATA_WIDTH-2:0],
                         mosi_sy[2]};
          rx_valid_q <= 1'b1;
        end else
          bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  assign bus.miso        = (state_q == ACTIVE) &
                           tx_sr[DATA_WIDTH-1];
  assign bus.miso_oe     = (state_q == ACTIVE);
  assign bus.busy        = (state_q == ACTIVE);
  assign bus.tx_ready    = tx_ready;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = ur_q;
  assign bus.frame_err   = fe_q;
  assign bus.irq         = rx_valid_q | ur_q | fe_q;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode,
// queue model of the tx path, pulse counters.
module tb_spi_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [3:0] sclk_v = 4'b1100;
  logic [3:0] ss_v   = 4'b1111;
  logic [3:0] mosi_v = 4'b0000;
  logic [3:0] txv_v  = 4'b0000;
  logic [15:0] txd_v [4] = '{16'h0, 16'h0, 16'h0, 16'h0};

  wire [3:0] miso_v, oe_v, rdy_v, rxv_v;
  wire [3:0] busy_v, irq_v, ur_v, fe_v;
  wire [15:0] rxd_v [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_if #(.DATA_WIDTH(16)) bus ();
    assign bus.sclk     = sclk_v[g];
    assign bus.ss_n     = ss_v[g];
    assign bus.mosi     = mosi_v[g];
    assign bus.tx_data  = txd_v[g];
    assign bus.tx_valid = txv_v[g];
    assign miso_v[g] = bus.miso;
    assign oe_v[g]   = bus.miso_oe;
    assign rdy_v[g]  = bus.tx_ready;
    assign rxd_v[g]  = bus.rx_data;
    assign rxv_v[g]  = bus.rx_valid;
    assign busy_v[g] = bus.busy;
    assign irq_v[g]  = bus.irq;
    assign ur_v[g]   = bus.tx_underrun;
    assign fe_v[g]   = bus.frame_err;
    spi_slave #(.MODE(g), .DATA_WIDTH(16)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  int n_rxv [4] = '{0, 0, 0, 0};
  int n_ur  [4] = '{0, 0, 0, 0};
  int n_fe  [4] = '{0, 0, 0, 0};
  int n_irq [4] = '{0, 0, 0, 0};
  int n_bsy [4] = '{0, 0, 0, 0};
  int n_mi1 [4] = '{0, 0, 0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rxv_v[i])  n_rxv[i] <= n_rxv[i] + 1;
      if (ur_v[i])   n_ur[i]  <= n_ur[i] + 1;
      if (fe_v[i])   n_fe[i]  <= n_fe[i] + 1;
      if (irq_v[i])  n_irq[i] <= n_irq[i] + 1;
      if (busy_v[i]) n_bsy[i] <= n_bsy[i] + 1;
      if (miso_v[i]) n_mi1[i] <= n_mi1[i] + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  // tx model: words queued in the holding register
  logic [15:0] mq [$];
  logic [15:0] m_cur;
  bit          m_cur_ur;
  int e_rxv, e_ur, e_fe;
  int b_rxv, b_ur, b_fe, b_irq, b_bsy, b_mi1;

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic void m_load();
    if (mq.size() > 0) begin
      m_cur    = mq.pop_front();
      m_cur_ur = 1'b0;
    end else begin
      m_cur    = 16'h0;
      m_cur_ur = 1'b1;
    end
  endfunction

  task automatic snap(int m);
    b_rxv = n_rxv[m];
    b_ur  = n_ur[m];
    b_fe  = n_fe[m];
    b_irq = n_irq[m];
    b_bsy = n_bsy[m];
    b_mi1 = n_mi1[m];
    e_rxv = 0;
    e_ur  = 0;
    e_fe  = 0;
  endtask

  task automatic endchk(int m, string tag);
    chk({tag, "_rxv"}, n_rxv[m] - b_rxv, e_rxv);
    chk({tag, "_ur"}, n_ur[m] - b_ur, e_ur);
    chk({tag, "_fe"}, n_fe[m] - b_fe, e_fe);
    chk({tag, "_irq"}, n_irq[m] - b_irq,
        e_rxv + e_ur + e_fe);
  endtask

  task automatic push(int m, logic [15:0] w);
    int k = 0;
    while (!rdy_v[m] && k < 300) begin
      tick(1);
      k++;
    end
    chk("tx_ready_wait", rdy_v[m], 1'b1);
    txd_v[m] = w;
    txv_v[m] = 1'b1;
    tick(1);
    txv_v[m] = 1'b0;
    mq.push_back(w);
  endtask

  task automatic xfer(int m, int nb,
                      logic [15:0] mo,
                      output logic [15:0] mi);
    logic cpol = m[1];
    logic cpha = m[0];
    mi = 16'h0;
    for (int i = 15; i > 15 - nb; i--) begin
      if (!cpha) begin
        mosi_v[m] = mo[i];
        tick(4);
        mi[i] = miso_v[m];
        sclk_v[m] = ~cpol;
        tick(4);
        sclk_v[m] = cpol;
      end else begin
        sclk_v[m] = ~cpol;
        mosi_v[m] = mo[i];
        tick(4);
        mi[i] = miso_v[m];
        sclk_v[m] = cpol;
        tick(4);
      end
    end
    if (!cpha) tick(4);
  endtask

  task automatic sel(int m);
    ss_v[m] = 1'b0;
    m_load();
    tick(6);
  endtask

  task automatic desel(int m);
    ss_v[m] = 1'b1;
    tick(8);
  endtask

  task automatic frame(int m, logic [15:0] mo,
                       string tag);
    logic [15:0] mi;
    e_ur += int'(m_cur_ur);
    xfer(m, 16, mo, mi);
    chk({tag, "_miso"}, mi, m_cur);
    chk({tag, "_rx"}, rxd_v[m], mo);
    e_rxv++;
    m_load();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] mi, r, rx_keep;
    rst = 1'b1;
    tick(4);
    rst = 1'b0;
    tick(8);

    for (int m = 0; m < 4; m++) begin
      chk("rst_busy", busy_v[m], 1'b0);
      chk("rst_oe", oe_v[m], 1'b0);
      chk("rst_miso", miso_v[m], 1'b0);
      chk("rst_rdy", rdy_v[m], 1'b1);
      chk("rst_rx", rxd_v[m], 16'h0);
      chk("rst_irq", irq_v[m], 1'b0);
    end

    // Mode 0 basic exchange
    mq.delete();
    snap(0);
    push(0, 16'h55AA);
    chk("a_rdy_full", rdy_v[0], 1'b0);
    sel(0);
    chk("a_rdy_sel", rdy_v[0], 1'b1);
    chk("a_busy", busy_v[0], 1'b1);
    chk("a_oe", oe_v[0], 1'b1);
    frame(0, 16'hAA55, "a");
    desel(0);
    chk("a_busy_end", busy_v[0], 1'b0);
    endchk(0, "a");

    // Every mode, fixed words
    for (int m = 0; m < 4; m++) begin
      mq.delete();
      snap(m);
      push(m, 16'hCCCC);
      sel(m);
      frame(m, 16'h1234, "b");
      desel(m);
      endchk(m, "b");
    end

    // Underrun: nothing queued
    mq.delete();
    snap(0);
    sel(0);
    frame(0, 16'h0000, "c");
    desel(0);
    chk("c_miso_hi", n_mi1[0] - b_mi1, 0);
    endchk(0, "c");

    // Three back-to-back frames
    mq.delete();
    snap(0);
    push(0, 16'($urandom));
    sel(0);
    push(0, 16'($urandom));
    frame(0, 16'h0000, "d0");
    push(0, 16'($urandom));
    frame(0, 16'h1111, "d1");
    frame(0, 16'h2222, "d2");
    desel(0);
    endchk(0, "d");

    // Random words, back-to-back, every mode
    for (int m = 0; m < 4; m++) begin
      mq.delete();
      snap(m);
      push(m, 16'($urandom));
      sel(m);
      push(m, 16'($urandom));
      frame(m, 16'($urandom), "g0");
      if ($urandom_range(1, 0) == 1)
        push(m, 16'($urandom));
      frame(m, 16'($urandom), "g1");
      desel(m);
      endchk(m, "g");
    end

    // Deselect after 7 bits
    mq.delete();
    rx_keep = rxd_v[0];
    snap(0);
    push(0, 16'h0F0F);
    sel(0);
    e_ur += int'(m_cur_ur);
    xfer(0, 7, 16'hFFFF, mi);
    desel(0);
    e_fe = 1;
    chk("e_rx_keep", rxd_v[0], rx_keep);
    chk("e_busy", busy_v[0], 1'b0);
    chk("e_rdy", rdy_v[0], 1'b1);
    endchk(0, "e");

    // Reset mid-frame, ss_n held low afterwards
    mq.delete();
    push(0, 16'h1357);
    sel(0);
    xfer(0, 5, 16'hFFFF, mi);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    mq.delete();
    tick(2);
    snap(0);
    r = 16'($urandom);
    xfer(0, 16, r, mi);
    tick(8);
    chk("f_busy_cnt", n_bsy[0] - b_bsy, 0);
    chk("f_oe", oe_v[0], 1'b0);
    chk("f_rx", rxd_v[0], 16'h0);
    endchk(0, "f_idle");
    desel(0);
    snap(0);
    push(0, 16'h2468);
    sel(0);
    chk("f_busy_again", busy_v[0], 1'b1);
    frame(0, r, "f");
    desel(0);
    endchk(0, "f");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
